// File: rtl/sfp_link_watchdog.sv
// Link supervisor: restarts the GTH/core reset sequence when the Aurora link fails to come up or drops.
// Debounces channel_up, bounds retries, and reports status and counters. All outputs are registered.
module sfp_link_watchdog #(
  parameter int unsigned LINK_TIMEOUT = 100000,
  parameter int unsigned DEBOUNCE     = 1024,
  parameter int unsigned MAX_RETRY    = 8,
  parameter int unsigned PULSE_LEN    = 64
) (
  input  logic        init_clk,
  input  logic        sys_rst,
  input  logic        reset_pb,
  input  logic        channel_up,
  input  logic        hard_err,
  output logic        reinit_req,
  output logic        link_ok,
  output logic        link_fail,
  output logic [7:0]  retry_cnt,
  output logic [15:0] loss_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    WAIT_RST = 3'd0,
    WAIT_UP  = 3'd1,
    DEBNC    = 3'd2,
    UP       = 3'd3,
    REINIT   = 3'd4,
    FAILED   = 3'd5
  } state_e;

  localparam logic [31:0] TMO_LAST   = 32'(LINK_TIMEOUT - 1);
  localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE - 1);
  localparam logic [15:0] PULSE_LAST = 16'(PULSE_LEN - 1);
  localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);

  state_e      state_q, state_d;
  logic        seen_rst_q, seen_rst_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] deb_q, deb_d;
  logic [15:0] pulse_q, pulse_d;
  logic [7:0]  retry_q, retry_d;
  logic [15:0] loss_q, loss_d;
  logic        reinit_req_q, reinit_req_d;
  logic        link_ok_q, link_ok_d;
  logic        link_fail_q, link_fail_d;
  logic        lost;
  logic        expired;

  always_ff @(posedge init_clk) begin
    if (sys_rst) begin
      state_q      <= WAIT_RST;
      seen_rst_q   <= 1'b0;
      timer_q      <= '0;
      deb_q        <= '0;
      pulse_q      <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      reinit_req_q <= 1'b0;
      link_ok_q    <= 1'b0;
      link_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      seen_rst_q   <= seen_rst_d;
      timer_q      <= timer_d;
      deb_q        <= deb_d;
      pulse_q      <= pulse_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      reinit_req_q <= reinit_req_d;
      link_ok_q    <= link_ok_d;
      link_fail_q  <= link_fail_d;
    end
  end

  // >= rather than == so an expiry deferred by a fresh channel_up edge is still caught a cycle later
  assign expired = (timer_q >= TMO_LAST);

  always_comb begin
    state_d    = state_q;
    seen_rst_d = seen_rst_q;
    timer_d    = timer_q;
    deb_d      = deb_q;
    pulse_d    = pulse_q;
    retry_d    = retry_q;
    loss_d     = loss_q;
    lost       = 1'b0;

    case (state_q)
      WAIT_RST: begin
        if (reset_pb) seen_rst_d = 1'b1;
        if (seen_rst_q && !reset_pb) begin
          state_d = WAIT_UP;
          timer_d = '0;
        end
      end
      WAIT_UP: begin
        timer_d = timer_q + 32'd1;
        if (channel_up) begin
          deb_d   = 16'd1;
          state_d = (DEBOUNCE == 1) ? UP : DEBNC;
        end else if (expired) begin
          lost = 1'b1;
        end
      end
      DEBNC: begin
        timer_d = timer_q + 32'd1;
        if (channel_up && (deb_q == DEB_LAST)) begin
          state_d = UP;
        end else if (expired) begin
          lost = 1'b1;
        end else if (!channel_up) begin
          state_d = WAIT_UP;
        end else begin
          deb_d = deb_q + 16'd1;
        end
      end
      UP: begin
        if (!channel_up || hard_err) begin
          lost = 1'b1;
          if (loss_q != 16'hFFFF) loss_d = loss_q + 16'd1;
        end
      end
      REINIT: begin
        pulse_d = pulse_q + 16'd1;
        if (pulse_q == PULSE_LAST) begin
          state_d    = WAIT_RST;
          seen_rst_d = 1'b0;
        end
      end
      FAILED: begin
        state_d = FAILED;
      end
      default: begin
        state_d = WAIT_RST;
      end
    endcase

    if (lost) begin
      if (retry_q == RETRY_MAX) begin
        state_d = FAILED;
      end else begin
        state_d = REINIT;
        retry_d = retry_q + 8'd1;
        pulse_d = '0;
      end
    end
  end

  always_comb begin
    reinit_req_d = (state_d == REINIT);
    link_ok_d    = (state_d == UP);
    link_fail_d  = (state_d == FAILED);
  end

  assign reinit_req = reinit_req_q;
  assign link_ok    = link_ok_q;
  assign link_fail  = link_fail_q;
  assign retry_cnt  = retry_q;
  assign loss_cnt   = loss_q;
  assign state      = state_q;

endmodule
